inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Boot-time instruction memory that is the responder side of the core's fetch port. A byte-stream loader fills the memory with big-endian MIPS words while the core is held in reset. The block then answers fetch requests (`rom_ce`, `rom_addr`) with instruction words in the same cycle. It sits beside the CPU top, driving its `rom_data_i` and its reset hold.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits. Depth is DEPTH = 2^ADDR_WIDTH words.
- `clk` input, 1 bit: the only clock. All state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous assert, active-low.
- `load_valid_i` input, 1 bit: a load byte is present.
- `load_data_i` input, 8 bits: the load byte.
- `load_last_i` input, 1 bit: qualifies the current byte as the final byte of the image.
- `load_ready_o` output, 1 bit: the block accepts a byte this cycle.
- `core_hold_o` output, 1 bit: holds the CPU in reset while high.
- `load_done_o` output, 1 bit: high in the RUN state.
- `err_o` output, 1 bit: sticky error flag.
- `word_count_o` output, ADDR_WIDTH+1 bits: number of words written.
- `rom_ce_i` input, 1 bit: fetch enable from the core.
- `rom_addr_i` input, 32 bits: byte address from the core (the pc).
- `rom_data_o` output, 32 bits: the instruction word.

## Operation
- **Storage:** DEPTH x 32 register array, not reset. Internal state: `byte_cnt` (2 bits), `shift` (24 bits), `word_count`, FSM, `err`.
- **States:** LOAD, RUN, ERR. Reset enters LOAD.
- **Byte acceptance:** a byte is accepted when `load_valid_i && load_ready_o`.
- **LOAD state:**
  - `load_ready_o`=1, `core_hold_o`=1.
  - The first byte of a word lands in bits 31:24, the second in 23:16, the third in 15:8, the fourth in 7:0 (big-endian).
  - On the 4th byte, write `{shift, byte}` to `mem[word_count]`, increment `word_count`, and clear `byte_cnt`.
  - Last byte accepted with `byte_cnt`==3: write the completed word, go to RUN.
  - Last byte accepted with `byte_cnt`<3: write the partial word zero-padded in its low bytes, increment `word_count`, set `err`, go to RUN.
  - Byte accepted while `word_count`==DEPTH: discard the byte, set `err`, go to ERR.
  - `load_last_i` is ignored when no byte is accepted.
- **RUN state:**
  - `load_ready_o`=0, `core_hold_o`=0, `load_done_o`=1.
  - Fetch response (combinational):
    - word index = `rom_addr_i[ADDR_WIDTH+1:2]`.
    - Address bits [1:0] and the bits above ADDR_WIDTH+1 are ignored, so addresses alias.
    - `rom_data_o` = 0 if `rom_ce_i`=0 or index >= `word_count`; otherwise `mem[index]`.
  - RUN is left only by reset.
- **ERR state:** `load_ready_o`=0, `core_hold_o`=1, `rom_data_o`=0, `err_o`=1. Left only by reset.
- **LOAD-state read:** `rom_data_o`=0 regardless of `rom_ce_i`.

## Timing
- **Reset values (asynchronous on `rst`=0):**
  - FSM=LOAD, `byte_cnt`=0, `shift`=0, `word_count`=0, `err`=0.
  - Outputs: `load_ready_o`=1, `core_hold_o`=1, `load_done_o`=0, `err_o`=0, `word_count_o`=0, `rom_data_o`=0.
  - Memory contents are undefined but unreadable, because `word_count`=0.
- **Reset mid-load:** all partial state is discarded; the next accepted byte is byte 0 of word 0.
- **Byte rate:** one byte per cycle. `load_ready_o` is a pure function of state, with no dependence on `load_valid_i`.
- **Word write timing:** a word write takes effect at the edge that accepts its 4th or last byte. `word_count_o` updates on the same edge.
- **Transition to RUN:** the state changes at the edge accepting the last byte. `core_hold_o` falls and `load_ready_o` falls in the following cycle, both registered.
- **Fetch latency:** `rom_data_o` has zero-cycle latency from `rom_addr_i`/`rom_ce_i`. The core samples it at the next edge through its IF/ID register.
- **Fill to capacity:** the last byte completing word DEPTH-1 goes to RUN with `err`=0. Without last, the block stays in LOAD, and the next accepted byte causes ERR.
- **Stall:** `load_valid_i`=1 while `load_ready_o`=0 has no effect.

## Test plan
- **Basic load and fetch:**
  - Stimulus: load 0x34,0x01,0x11,0x00,0x34,0x02,0x00,0x20 (last on the 8th byte).
  - Response: `word_count_o`=2 and `core_hold_o`=0 one cycle after the last byte.
  - Fetch addr 0x0 returns 0x34011100; addr 0x4 returns 0x34020020; addr 0x8 returns 0; addr 0x2 returns 0x34011100.
- **Partial word:**
  - Stimulus: load 5 bytes 0x00,0x00,0x00,0x01,0xAB, last on 0xAB.
  - Response: word1=0xAB000000, `word_count_o`=2, `err_o`=1, state RUN.
- **Overflow (ADDR_WIDTH=2):**
  - Stimulus: 17 bytes, none marked last.
  - Response: after the 16th byte, `word_count_o`=4 and the block is still in LOAD. The 17th byte gives ERR: `err_o`=1, `load_ready_o`=0, `core_hold_o`=1, `rom_data_o`=0.
- **Exact fill (ADDR_WIDTH=2):**
  - Stimulus: 16 bytes, last on the 16th.
  - Response: RUN with `err_o`=0; fetch 0xC returns word3, and fetch 0x10 aliases to word0.
- **Gapped valid and reset mid-load:**
  - Stimulus: bytes with idle cycles between them; assert `rst`=0 after 2 bytes, then load 0xDE,0xAD,0xBE,0xEF with last.
  - Response: word0=0xDEADBEEF and `word_count_o`=1.
- **Fetch disabled:**
  - Stimulus: in RUN, drive `rom_ce_i`=0 with a valid address.
  - Response: `rom_data_o`=0.

Source files
------------

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-time byte-stream loaded instruction ROM answering core fetches combinationally
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  core_hold_o,
  output logic                  load_done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {LOAD, RUN, ERR} state_t;
  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  err_q, err_d;
  logic [31:0]           mem [DEPTH];
  logic                  accept, full, wr_en;
  logic [31:0]           wr_data;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  unused_addr;
  assign accept = load_valid_i && (state_q == LOAD);
  // word_count never exceeds DEPTH, so its top bit alone marks a full memory
  assign full = word_count_q[ADDR_WIDTH];
  // partial words are left-aligned: missing trailing bytes read as zero
  assign wr_data = (byte_cnt_q == 2'd0) ? {load_data_i, 24'h0} :
                   (byte_cnt_q == 2'd1) ? {shift_q[7:0], load_data_i, 16'h0} :
                   (byte_cnt_q == 2'd2) ? {shift_q[15:0], load_data_i, 8'h0} :
                                          {shift_q, load_data_i};
  // next-state: assemble bytes, commit words, and pick LOAD/RUN/ERR
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    wr_en        = 1'b0;
    if (accept && full) begin
      err_d   = 1'b1;
      state_d = ERR;
    end else if (accept && (load_last_i || byte_cnt_q == 2'd3)) begin
      wr_en        = 1'b1;
      word_count_d = word_count_q + 1'b1;
      byte_cnt_d   = 2'd0;
      shift_d      = 24'h0;
      state_d      = load_last_i ? RUN : LOAD;
      err_d        = err_q | (load_last_i && byte_cnt_q != 2'd3);
    end else if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], load_data_i};
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LOAD;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'h0;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
    end
  end
  // instruction storage is not reset; word_count gates every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_count_q[ADDR_WIDTH-1:0]] <= wr_data;
  end
  assign rd_idx       = rom_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr  = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};
  assign rom_data_o   = (state_q == RUN && rom_ce_i && {1'b0, rd_idx} < word_count_q) ? mem[rd_idx] : 32'h0;
  assign load_ready_o = (state_q == LOAD);
  assign core_hold_o  = (state_q != RUN);
  assign load_done_o  = (state_q == RUN);
  assign err_o        = err_q;
  assign word_count_o = word_count_q;
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: directed and randomized checks of the loader against an image-level model
module tb_inst_rom_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int CAP   = DEPTH * 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid_i = 1'b0;
  logic [7:0]  load_data_i = 8'h0;
  logic        load_last_i = 1'b0;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = 32'h0;
  logic        load_ready_o, core_hold_o, load_done_o, err_o;
  logic [AW:0] word_count_o;
  logic [31:0] rom_data_o;
  int checks = 0;
  int failures = 0;
  logic [7:0] img[$];
  bit img_last = 1'b0;

  inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_last_i(load_last_i),
    .load_ready_o(load_ready_o), .core_hold_o(core_hold_o), .load_done_o(load_done_o),
    .err_o(err_o), .word_count_o(word_count_o),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // model: 0=LOAD 1=RUN 2=ERR, derived from the accepted byte image only
  function automatic int m_state();
    if (img.size() > CAP) return 2;
    return img_last ? 1 : 0;
  endfunction

  function automatic int m_wc();
    if (img.size() > CAP) return DEPTH;
    return img_last ? (img.size() + 3) / 4 : img.size() / 4;
  endfunction

  function automatic logic m_err();
    return (img.size() > CAP) || (img_last && (img.size() % 4) != 0);
  endfunction

  function automatic logic [31:0] m_word(input int i);
    logic [31:0] w = 32'h0;
    for (int k = 0; k < 4; k++)
      if (4 * i + k < img.size()) w[31 - 8 * k -: 8] = img[4 * i + k];
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h0;
    #1;
    chk("rst_ready", 32'(load_ready_o), 32'd1);
    chk("rst_hold", 32'(core_hold_o), 32'd1);
    chk("rst_done", 32'(load_done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_wc", 32'(word_count_o), 32'd0);
    chk("rst_data", rom_data_o, 32'h0);
    img.delete();
    img_last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // offer one byte after gap idle cycles; the model keeps it only if the block is accepting
  task automatic send(input logic [7:0] b, input bit last, input int gap);
    repeat (gap) begin
      @(negedge clk);
      load_last_i = 1'($urandom_range(0, 1));
    end
    load_valid_i = 1'b1;
    load_data_i  = b;
    load_last_i  = last;
    if (m_state() == 0) begin
      img.push_back(b);
      img_last = last;
    end
    @(negedge clk);
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic fetch(input string tag, input bit ce, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    rom_ce_i = ce;
    rom_addr_i = addr;
    #1;
    chk(tag, rom_data_o, exp);
  endtask

  task automatic check_model(input string tag);
    int st;
    st = m_state();
    chk({tag, "_ready"}, 32'(load_ready_o), 32'(st == 0));
    chk({tag, "_hold"}, 32'(core_hold_o), 32'(st != 1));
    chk({tag, "_done"}, 32'(load_done_o), 32'(st == 1));
    chk({tag, "_err"}, 32'(err_o), 32'(m_err()));
    chk({tag, "_wc"}, 32'(word_count_o), 32'(m_wc()));
    for (int i = 0; i < DEPTH; i++) begin
      bit ce;
      logic [31:0] addr;
      ce = ($urandom_range(0, 3) != 0);
      addr = {$urandom_range(0, 32'h3FFFFFF), 6'h0} | 32'(i * 4) | 32'($urandom_range(0, 3));
      fetch({tag, "_fetch"}, ce, addr, (st == 1 && ce && i < m_wc()) ? m_word(i) : 32'h0);
    end
  endtask

  initial begin
    logic [7:0] basic [8] = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    logic [7:0] part [5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAB};
    logic [7:0] dead [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    // basic load and fetch
    do_reset();
    for (int i = 0; i < 8; i++) send(basic[i], i == 7, 0);
    chk("basic_wc", 32'(word_count_o), 32'd2);
    chk("basic_hold", 32'(core_hold_o), 32'd0);
    chk("basic_ready", 32'(load_ready_o), 32'd0);
    fetch("basic_a0", 1'b1, 32'h0, 32'h34011100);
    fetch("basic_a4", 1'b1, 32'h4, 32'h34020020);
    fetch("basic_a8", 1'b1, 32'h8, 32'h0);
    fetch("basic_a2", 1'b1, 32'h2, 32'h34011100);
    fetch("basic_ce0", 1'b0, 32'h4, 32'h0);
    send(8'h55, 1'b1, 0);
    check_model("basic_stall");
    // partial trailing word
    do_reset();
    for (int i = 0; i < 5; i++) send(part[i], i == 4, 0);
    fetch("part_w0", 1'b1, 32'h0, 32'h00000001);
    fetch("part_w1", 1'b1, 32'h4, 32'hAB000000);
    chk("part_wc", 32'(word_count_o), 32'd2);
    chk("part_err", 32'(err_o), 32'd1);
    chk("part_done", 32'(load_done_o), 32'd1);
    // overflow
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i + 8'h40), 1'b0, 0);
    chk("ovf_wc16", 32'(word_count_o), 32'd4);
    chk("ovf_ready16", 32'(load_ready_o), 32'd1);
    chk("ovf_hold16", 32'(core_hold_o), 32'd1);
    send(8'h99, 1'b0, 0);
    chk("ovf_err", 32'(err_o), 32'd1);
    chk("ovf_ready", 32'(load_ready_o), 32'd0);
    chk("ovf_hold", 32'(core_hold_o), 32'd1);
    fetch("ovf_data", 1'b1, 32'h0, 32'h0);
    // exact fill
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), i == 15, 0);
    chk("fill_err", 32'(err_o), 32'd0);
    chk("fill_done", 32'(load_done_o), 32'd1);
    fetch("fill_c", 1'b1, 32'hC, 32'h0C0D0E0F);
    fetch("fill_alias", 1'b1, 32'h10, 32'h00010203);
    // gapped bytes with reset mid-load
    do_reset();
    send(8'h11, 1'b0, 2);
    send(8'h22, 1'b0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) send(dead[i], i == 3, i % 3);
    fetch("rstmid_w0", 1'b1, 32'h0, 32'hDEADBEEF);
    chk("rstmid_wc", 32'(word_count_o), 32'd1);
    chk("rstmid_err", 32'(err_o), 32'd0);
    // randomized images against the model
    for (int r = 0; r < 30; r++) begin
      int n;
      bit lf;
      do_reset();
      n  = $urandom_range(1, 20);
      lf = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        send(8'($urandom), lf && (i == n - 1), $urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) check_model("rnd_mid");
      end
      check_model("rnd_end");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
